// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the bit-serial subtractor.
// The requester drives start/a/b; the subtractor returns status and the held result.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one full-subtractor
// cell plus a borrow flop, one bit per clock (IDLE -> RUN -> DONE -> IDLE).
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    logic             d_c;
    logic             br_c;
    logic [WIDTH-1:0] res_c;

    // Full-subtractor cell on the current LSBs and the running borrow.
    always_comb begin
        d_c   = a_sh[0] ^ b_sh[0] ^ br;
        br_c  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_c = {d_c, res[WIDTH-1:1]};
    end

    // Sequencer and datapath; the published result only moves on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        res   <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_c;
                    br   <= br_c;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        diff       <= res_c;
                        borrow_out <= br_c;
                        zero       <= (res_c == '0);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.diff       = diff;
    assign bus.borrow_out = borrow_out;
    assign bus.zero       = zero;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at issue
// and compared by an independent monitor on every done pulse.
module tb_serial_subtractor;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned N_RAND  = 2000;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t             exp_q[$];
    int               checks     = 0;
    int               passes     = 0;
    int               ops_issued = 0;
    int               dones_seen = 0;
    logic [WIDTH-1:0] held_diff;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Reference: plain unsigned arithmetic, one extra bit exposes the borrow.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] t;
        exp_t           e;
        t        = {1'b0, a} - {1'b0, b};
        e.diff   = t[WIDTH-1:0];
        e.borrow = (a < b);
        e.zero   = (a == b);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            dones_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = exp_q.pop_front();
                check("diff",       longint'(bus.diff),       longint'(e.diff));
                check("borrow_out", longint'(bus.borrow_out), longint'(e.borrow));
                check("zero",       longint'(bus.zero),       longint'(e.zero));
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit timing, input bit inject);
        int   busy_cnt;
        int   lat;
        exp_t e;
        @(negedge clk);
        e          = model(a, b);
        bus.a      = a;
        bus.b      = b;
        bus.start  = 1'b1;
        exp_q.push_back(e);
        ops_issued++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        busy_cnt  = 0;
        lat       = 0;
        for (int k = 1; k <= 3 * WIDTH; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (timing && k == 3) check("hold_in_run", longint'(bus.diff), longint'(held_diff));
            if (inject && k == 3) begin
                bus.a     = WIDTH'(1);
                bus.b     = WIDTH'(1);
                bus.start = 1'b1;
            end
            if (inject && k == 4) bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", 3 * WIDTH);
        end else begin
            held_diff = e.diff;
            if (timing) begin
                check("latency", lat, WIDTH + 1);
                @(negedge clk);
                if (bus.busy) busy_cnt++;
                check("busy_cycles", busy_cnt, WIDTH + 1);
                check("done_one_cycle", longint'(bus.done), 0);
            end
        end
    endtask

    initial begin : stim
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        held_diff = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   longint'(bus.busy),       0);
        check("rst_done",   longint'(bus.done),       0);
        check("rst_diff",   longint'(bus.diff),       0);
        check("rst_borrow", longint'(bus.borrow_out), 0);
        check("rst_zero",   longint'(bus.zero),       0);
        rst_n = 1'b1;

        run_op(8'd200, 8'd55,  1'b1, 1'b0);
        run_op(8'd5,   8'd9,   1'b1, 1'b0);
        run_op(8'd0,   8'd255, 1'b1, 1'b0);
        run_op(8'd0,   8'd0,   1'b1, 1'b0);
        run_op(8'd77,  8'd77,  1'b1, 1'b0);
        run_op(8'd100, 8'd30,  1'b1, 1'b1);

        repeat (3) @(negedge clk);
        check("hold_idle", longint'(bus.diff), longint'(held_diff));

        // Abort an operation four cycles into RUN.
        @(negedge clk);
        bus.a     = 8'd50;
        bus.b     = 8'd20;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy",   longint'(bus.busy),       0);
        check("abort_done",   longint'(bus.done),       0);
        check("abort_diff",   longint'(bus.diff),       0);
        check("abort_borrow", longint'(bus.borrow_out), 0);
        held_diff = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd50, 8'd20, 1'b1, 1'b0);

        for (int i = 0; i < N_RAND; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            case ($urandom_range(0, 15))
                0: ra = '0;
                1: rb = '1;
                2: rb = ra;
                3: ra = '1;
                default: ;
            endcase
            run_op(ra, rb, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("done_count",    dones_seen, ops_issued);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #(1_000_000);
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
